reg_cmd_sched: RTL and testbench

- Round-robin command scheduler that shares one general-purpose register block (cl/ld/inc/dec/sr/sl/il/ir control set) between NUM_REQ requesters.
- Accepts one command at a time over a valid/ready interface and expands repeat counts into per-cycle one-hot control strobes.
- Returns the register's final value over a valid/ready response channel.
- Sits between the datapath register and the requesting FSMs.

---
 rtl/reg_cmd_sched_if.sv | 29 ++
 rtl/reg_cmd_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_reg_cmd_sched.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_cmd_sched_if.sv
// Command/response channel between the requesting FSMs and reg_cmd_sched.
// master = requester side, slave = scheduler side.
interface reg_cmd_sched_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 4,
  parameter int ID_WIDTH   = 1
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [3*NUM_REQ-1:0]          req_op;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_arg;
  logic [CNT_WIDTH*NUM_REQ-1:0]  req_rpt;
  logic [NUM_REQ-1:0]            req_sin;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_op, req_arg, req_rpt, req_sin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_arg, req_rpt, req_sin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/reg_cmd_sched.sv
// Round-robin scheduler expanding requester commands into one-hot strobes for a
// shared register block. Optional abort input: define REG_CMD_SCHED_ABORT_EN.
module reg_cmd_sched #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 4,
  parameter int ID_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_cmd_sched_if.slave        cmd,
  output logic                  reg_cl,
  output logic                  reg_ld,
  output logic                  reg_inc,
  output logic                  reg_dec,
  output logic                  reg_sr,
  output logic                  reg_sl,
  output logic                  reg_il,
  output logic                  reg_ir,
  output logic [DATA_WIDTH-1:0] reg_in,
  input  logic [DATA_WIDTH-1:0] reg_q
`ifdef REG_CMD_SCHED_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  rsp_aborted
`endif
);

  localparam int STEP_W = CNT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_READ = 3'd7
  } op_t;

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [DATA_WIDTH-1:0] arg_q, arg_d;
  logic                  sin_q, sin_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [STEP_W-1:0]     cnt_q, cnt_d;

  logic                  hit_hi, hit_lo, sel_found;
  logic [ID_WIDTH-1:0]   idx_hi, idx_lo, sel_idx;
  logic [2:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_arg;
  logic [CNT_WIDTH-1:0]  sel_rpt;
  logic                  sel_sin;
  logic [STEP_W-1:0]     sel_steps;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  abort_hit;
  logic                  step_en;

`ifdef REG_CMD_SCHED_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_hit   = abort;
  assign rsp_aborted = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Two passes: first valid at/above rr_ptr wins, else first valid from index 0.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!hit_hi && cmd.req_valid[j] && (j >= 32'(rr_ptr_q))) begin
        hit_hi = 1'b1;
        idx_hi = ID_WIDTH'(j);
      end
      if (!hit_lo && cmd.req_valid[j]) begin
        hit_lo = 1'b1;
        idx_lo = ID_WIDTH'(j);
      end
    end
    sel_found = hit_hi | hit_lo;
    sel_idx   = hit_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    sel_op  = '0;
    sel_arg = '0;
    sel_rpt = '0;
    sel_sin = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (32'(sel_idx) == j) begin
        sel_op  = cmd.req_op[3*j +: 3];
        sel_arg = cmd.req_arg[DATA_WIDTH*j +: DATA_WIDTH];
        sel_rpt = cmd.req_rpt[CNT_WIDTH*j +: CNT_WIDTH];
        sel_sin = cmd.req_sin[j];
      end
    end
  end

  // Counter is one bit wider than rpt so rpt=all-ones yields 2^CNT_WIDTH steps.
  always_comb begin
    unique case (op_t'(sel_op))
      OP_INC, OP_DEC, OP_SHR, OP_SHL: sel_steps = {1'b0, sel_rpt} + STEP_W'(1);
      OP_CLR, OP_LOAD:                sel_steps = STEP_W'(1);
      default:                        sel_steps = '0;
    endcase
  end

  assign step_en = !abort_hit;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    arg_d    = arg_q;
    sin_d    = sin_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
`ifdef REG_CMD_SCHED_ABORT_EN
    aborted_d = aborted_q;
`endif
    req_ready = '0;
    reg_cl    = 1'b0;
    reg_ld    = 1'b0;
    reg_inc   = 1'b0;
    reg_dec   = 1'b0;
    reg_sr    = 1'b0;
    reg_sl    = 1'b0;
    reg_il    = 1'b0;
    reg_ir    = 1'b0;
    reg_in    = '0;

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          req_ready = NUM_REQ'(1) << sel_idx;
          op_d      = op_t'(sel_op);
          arg_d     = sel_arg;
          sin_d     = sel_sin;
          id_d      = sel_idx;
          cnt_d     = sel_steps;
          state_d   = (sel_steps == '0) ? RESP : EXEC;
        end
      end

      EXEC: begin
        unique case (op_q)
          OP_CLR:  reg_cl = step_en;
          OP_LOAD: begin
            reg_ld = step_en;
            reg_in = step_en ? arg_q : '0;
          end
          OP_INC:  reg_inc = step_en;
          OP_DEC:  reg_dec = step_en;
          OP_SHR: begin
            reg_sr = step_en;
            reg_il = step_en & sin_q;
          end
          OP_SHL: begin
            reg_sl = step_en;
            reg_ir = step_en & sin_q;
          end
          default: ;
        endcase
        cnt_d = cnt_q - STEP_W'(1);
        if (abort_hit || cnt_q <= STEP_W'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
        end
`ifdef REG_CMD_SCHED_ABORT_EN
        if (abort_hit) aborted_d = 1'b1;
`endif
      end

      RESP: begin
        if (cmd.rsp_ready) begin
          state_d  = IDLE;
          rr_ptr_d = (id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id_q + ID_WIDTH'(1);
`ifdef REG_CMD_SCHED_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_NOP;
      arg_q    <= '0;
      sin_q    <= 1'b0;
      id_q     <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
`ifdef REG_CMD_SCHED_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
      sin_q    <= sin_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef REG_CMD_SCHED_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign cmd.req_ready = req_ready;
  assign cmd.rsp_valid = (state_q == RESP);
  assign cmd.rsp_id    = id_q;
  assign cmd.rsp_data  = (state_q == RESP) ? reg_q : '0;

endmodule

// File: tb/tb_reg_cmd_sched.sv
// Bench for reg_cmd_sched: directed cases then random commands, checked against
// an arithmetic model of round-robin grants, step counts and final register values.
module tb_reg_cmd_sched;
  localparam int NR = 2;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_il, reg_ir;
  logic [DW-1:0] reg_in;
  logic [DW-1:0] reg_q = '0;
`ifdef REG_CMD_SCHED_ABORT_EN
  logic          abort = 1'b0;
  logic          rsp_aborted;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  int            rr_m = 0;
  logic [DW-1:0] exp_reg = '0;
  int            op_a [NR];
  logic [DW-1:0] arg_a[NR];
  int            rpt_a[NR];
  bit            sin_a[NR];

  reg_cmd_sched_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .ID_WIDTH(IW)) bus ();

  reg_cmd_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .ID_WIDTH(IW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (bus),
    .reg_cl  (reg_cl),
    .reg_ld  (reg_ld),
    .reg_inc (reg_inc),
    .reg_dec (reg_dec),
    .reg_sr  (reg_sr),
    .reg_sl  (reg_sl),
    .reg_il  (reg_il),
    .reg_ir  (reg_ir),
    .reg_in  (reg_in),
    .reg_q   (reg_q)
`ifdef REG_CMD_SCHED_ABORT_EN
    ,
    .abort       (abort),
    .rsp_aborted (rsp_aborted)
`endif
  );

  always #5 clk = ~clk;

  // The shared general-purpose register the scheduler drives.
  always @(posedge clk) begin
    if (reg_cl)       reg_q <= '0;
    else if (reg_ld)  reg_q <= reg_in;
    else if (reg_inc) reg_q <= reg_q + 1'b1;
    else if (reg_dec) reg_q <= reg_q - 1'b1;
    else if (reg_sr)  reg_q <= {reg_il, reg_q[DW-1:1]};
    else if (reg_sl)  reg_q <= {reg_q[DW-2:0], reg_ir};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int steps_of(input int op, input int rpt);
    if (op >= 3 && op <= 6) return rpt + 1;
    if (op == 1 || op == 2) return 1;
    return 0;
  endfunction

  function automatic logic [DW-1:0] apply_cmd(input logic [DW-1:0] v, input int op,
                                               input logic [DW-1:0] arg, input int rpt,
                                               input bit sin);
    logic [2*DW-1:0] w;
    int n;
    n = rpt + 1;
    case (op)
      1: return '0;
      2: return arg;
      3: return v + DW'(n);
      4: return v - DW'(n);
      5: begin w = {{DW{sin}}, v} >> n; return w[DW-1:0]; end
      6: begin w = {v, {DW{sin}}} << n; return w[2*DW-1:DW]; end
      default: return v;
    endcase
  endfunction

  function automatic logic [5:0] stb_of(input int op);
    case (op)
      1: return 6'b100000;
      2: return 6'b010000;
      3: return 6'b001000;
      4: return 6'b000100;
      5: return 6'b000010;
      6: return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] stb_now();
    return {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};
  endfunction

  task automatic set_cmd(input int idx, input int op, input logic [DW-1:0] arg,
                         input int rpt, input bit sin);
    op_a[idx] = op; arg_a[idx] = arg; rpt_a[idx] = rpt; sin_a[idx] = sin;
  endtask

  task automatic drive_fields();
    for (int j = 0; j < NR; j++) begin
      bus.req_op[3*j +: 3]    = 3'(op_a[j]);
      bus.req_arg[DW*j +: DW] = arg_a[j];
      bus.req_rpt[CW*j +: CW] = CW'(rpt_a[j]);
      bus.req_sin[j]          = sin_a[j];
    end
  endtask

  task automatic randomize_fields();
    for (int j = 0; j < NR; j++)
      set_cmd(j, int'($urandom_range(0, 7)), DW'($urandom), int'($urandom_range(0, 15)),
              bit'($urandom_range(0, 1)));
  endtask

  // Starts just after a falling edge; returns just after a falling edge.
  task automatic txn(input logic [NR-1:0] vmask, input int hold);
    int g, steps, cyc, gop, grpt;
    logic [DW-1:0] garg, expv;
    bit gsin;
    drive_fields();
    bus.req_valid = vmask;
    #1;
    g = 0;
    for (int k = NR - 1; k >= 0; k--)
      if (vmask[(rr_m + k) % NR]) g = (rr_m + k) % NR;
    check("grant", 32'(bus.req_ready), 32'(1) << g);
    gop = op_a[g]; garg = arg_a[g]; grpt = rpt_a[g]; gsin = sin_a[g];
    steps = steps_of(gop, grpt);
    expv  = apply_cmd(exp_reg, gop, garg, grpt, gsin);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    randomize_fields();
    drive_fields();
    cyc = 1;
    while (!bus.rsp_valid && cyc <= 40) begin
      check("strobe", 32'(stb_now()), 32'(stb_of(gop)));
      check("reg_il", 32'(reg_il), (gop == 5) ? 32'(gsin) : 32'(0));
      check("reg_ir", 32'(reg_ir), (gop == 6) ? 32'(gsin) : 32'(0));
      check("reg_in", 32'(reg_in), (gop == 2) ? 32'(garg) : 32'(0));
      check("busy_ready", 32'(bus.req_ready), 32'(0));
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(steps + 1));
    bus.req_valid = '1;
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 32'(bus.rsp_valid), 32'(1));
      check("hold_data", 32'(bus.rsp_data), 32'(expv));
      check("hold_ready", 32'(bus.req_ready), 32'(0));
      @(negedge clk);
    end
    check("resp_strobe", 32'(stb_now()), 32'(0));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(1));
    check("rsp_data", 32'(bus.rsp_data), 32'(expv));
    check("rsp_id", 32'(bus.rsp_id), 32'(g));
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_drop", 32'(bus.rsp_valid), 32'(0));
    rr_m    = (g + 1) % NR;
    exp_reg = expv;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int j = 0; j < NR; j++) set_cmd(j, 0, '0, 0, 1'b0);
    drive_fields();
    #12;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_rsp_id", 32'(bus.rsp_id), 32'(0));
    check("rst_rsp_data", 32'(bus.rsp_data), 32'(0));
    check("rst_strobe", 32'({stb_now(), reg_il, reg_ir}), 32'(0));
    check("rst_reg_in", 32'(reg_in), 32'(0));
    check("rst_ready", 32'(bus.req_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    set_cmd(0, 2, 16'h1234, 0, 1'b0); txn(2'b01, 0);
    set_cmd(1, 2, 16'h00FF, 0, 1'b0); txn(2'b10, 0);
    set_cmd(1, 3, 16'h0000, 3, 1'b0); txn(2'b10, 1);
    for (int i = 0; i < 4; i++) begin
      set_cmd(0, 7, 16'h0000, 0, 1'b0);
      set_cmd(1, 7, 16'h0000, 0, 1'b0);
      txn(2'b11, 0);
    end
    set_cmd(0, 2, 16'h0001, 0, 1'b0); txn(2'b01, 0);
    set_cmd(0, 6, 16'h0000, 1, 1'b1); txn(2'b01, 5);
    set_cmd(1, 2, 16'hFFF8, 0, 1'b0); txn(2'b10, 0);
    set_cmd(1, 3, 16'h0000, 15, 1'b0); txn(2'b10, 0);

    // Reset in the second step of a DEC; the rr pointer must restart at 0.
    set_cmd(0, 2, 16'h0010, 0, 1'b0); txn(2'b01, 0);
    set_cmd(0, 4, 16'h0000, 7, 1'b0);
    drive_fields();
    bus.req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    check("dec_step1", 32'(reg_dec), 32'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobe", 32'({stb_now(), reg_il, reg_ir}), 32'(0));
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'(0));
    check("mid_rst_ready", 32'(bus.req_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = 0;
    exp_reg = 16'h0010 - 16'd1;
    set_cmd(0, 7, 16'h0000, 0, 1'b0);
    set_cmd(1, 7, 16'h0000, 0, 1'b0);
    txn(2'b11, 0);

`ifdef REG_CMD_SCHED_ABORT_EN
    set_cmd(0, 1, 16'h0000, 0, 1'b0); txn(2'b01, 0);
    set_cmd(0, 3, 16'h0000, 9, 1'b0);
    drive_fields();
    bus.req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_suppress", 32'(reg_inc), 32'(0));
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", 32'(bus.rsp_valid), 32'(1));
    check("abort_flag", 32'(rsp_aborted), 32'(1));
    check("abort_data", 32'(bus.rsp_data), 32'(16'h0002));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("abort_clear", 32'(rsp_aborted), 32'(0));
    rr_m = 1;
    exp_reg = 16'h0002;
`endif

    for (int t = 0; t < 150; t++) begin
      randomize_fields();
      txn(NR'($urandom_range(1, (1 << NR) - 1)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
